// File: rtl/usb_tx_pkg.sv
// ---------------------------------------------------------------------------
// usb_tx_pkg
//
// Types and constants shared by the USB full-speed line transmitter.
//
//   tx_state_t   : transmitter FSM states (IDLE, ACTIVE, SE0)
//   LINE_J       : {d_plus, d_minus} for the J state  (idle level)
//   LINE_K       : {d_plus, d_minus} for the K state
//   LINE_SE0     : {d_plus, d_minus} for single-ended zero (end of packet)
//   nrzi_toggle  : flips a J/K line level to the opposite level
//
// The line constants carry a LINE_ prefix so that they can share this
// package with the SE0 state name without colliding.
// ---------------------------------------------------------------------------
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SE0    = 2'd2
    } tx_state_t;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // Anything that is not J (including an unexpected SE0) toggles to J,
    // so the encoder can never produce SE1 from a corrupted level.
    function automatic logic [1:0] nrzi_toggle(input logic [1:0] level);
        return (level == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/transmit.sv
// ---------------------------------------------------------------------------
// transmit
//
// NRZI line encoder and driver for a USB full-speed transmitter. Takes a
// serial bit stream from an upstream shifter and drives the D+/D- pair with
// J/K levels, or SE0 while end-of-packet is requested. Both line outputs
// come straight from a register, so every response appears one clock after
// the edge that sampled the inputs.
//
// Ports
//   clk      in   bit-rate clock, rising-edge active
//   n_rst    in   asynchronous active-low reset (line forced to J)
//   data     in   serial data bit, valid when ready=1
//   ready    in   qualifies data for this cycle
//   eop      in   end-of-packet request, line driven SE0 while high;
//                 takes priority over ready in every state
//   d_plus   out  registered D+ level
//   d_minus  out  registered D- level
// ---------------------------------------------------------------------------
module transmit
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic data,
    input  logic ready,
    input  logic eop,
    output logic d_plus,
    output logic d_minus
);

    tx_state_t   state;
    tx_state_t   next_state;
    logic [1:0]  line;
    logic [1:0]  next_line;

    // The line register doubles as the NRZI reference: the next encoded
    // level is always derived from the level currently on the wire.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            line  <= LINE_J;
        end else begin
            state <= next_state;
            line  <= next_line;
        end
    end

    always_comb begin
        next_state = state;
        next_line  = line;

        if (eop) begin
            // Any bit presented together with eop is dropped.
            next_state = SE0;
            next_line  = LINE_SE0;
        end else begin
            case (state)
                IDLE: begin
                    next_line = LINE_J;
                    if (ready) begin
                        // First bit is encoded relative to the idle J level.
                        next_state = ACTIVE;
                        next_line  = data ? LINE_J : nrzi_toggle(LINE_J);
                    end
                end
                ACTIVE: begin
                    // ready=0 is an inter-byte gap: the level simply holds.
                    if (ready) begin
                        next_line = data ? line : nrzi_toggle(line);
                    end
                end
                SE0: begin
                    next_state = IDLE;
                    next_line  = LINE_J;
                end
                default: begin
                    next_state = IDLE;
                    next_line  = LINE_J;
                end
            endcase
        end
    end

    assign d_plus  = line[1];
    assign d_minus = line[0];

endmodule

// File: tb/tb_transmit.sv
// ---------------------------------------------------------------------------
// tb_transmit
//
// Directed bench for the USB full-speed line transmitter. Each task drives
// one scenario and compares the registered {d_plus, d_minus} pair against
// hand-computed J/K/SE0 sequences.
// ---------------------------------------------------------------------------
module tb_transmit;

    localparam logic [1:0] EXP_J   = 2'b10;
    localparam logic [1:0] EXP_K   = 2'b01;
    localparam logic [1:0] EXP_SE0 = 2'b00;

    logic tb_clk;
    logic tb_n_rst;
    logic tb_data;
    logic tb_ready;
    logic tb_eop;
    logic tb_d_plus;
    logic tb_d_minus;

    int vectors;
    int miscompares;

    transmit dut (
        .clk     (tb_clk),
        .n_rst   (tb_n_rst),
        .data    (tb_data),
        .ready   (tb_ready),
        .eop     (tb_eop),
        .d_plus  (tb_d_plus),
        .d_minus (tb_d_minus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Drives inputs 1 time unit after a rising edge, then waits for the next
    // rising edge and samples 1 unit later.
    task automatic drive_cycle(input logic d, input logic r, input logic e);
        tb_data  = d;
        tb_ready = r;
        tb_eop   = e;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic test_reset();
        tb_data  = 1'b0;
        tb_ready = 1'b0;
        tb_eop   = 1'b0;
        tb_n_rst = 1'b0;
        #2;
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_J) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_J);
        end
        @(posedge tb_clk);
        #1;
        tb_n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            vectors++;
            if ({tb_d_plus, tb_d_minus} !== EXP_J) begin
                miscompares++;
                $display("[TB] FAIL reset_hold[%0d]: got %b expected %b", i, {tb_d_plus, tb_d_minus}, EXP_J);
            end
        end
    endtask

    // Sync byte 0x80 sent LSB first from IDLE.
    task automatic test_sync_byte();
        logic [7:0] byte_val;
        logic [1:0] exp_seq [8];
        byte_val = 8'h80;
        exp_seq = '{EXP_K, EXP_J, EXP_K, EXP_J, EXP_K, EXP_J, EXP_K, EXP_K};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(byte_val[i], 1'b1, 1'b0);
            vectors++;
            if ({tb_d_plus, tb_d_minus} !== exp_seq[i]) begin
                miscompares++;
                $display("[TB] FAIL sync_bit[%0d]: got %b expected %b", i, {tb_d_plus, tb_d_minus}, exp_seq[i]);
            end
        end
    endtask

    // Line is at K after the sync byte; all ones must hold K, as must a gap.
    task automatic test_all_ones_and_gap();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            vectors++;
            if ({tb_d_plus, tb_d_minus} !== EXP_K) begin
                miscompares++;
                $display("[TB] FAIL ones_bit[%0d]: got %b expected %b", i, {tb_d_plus, tb_d_minus}, EXP_K);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            vectors++;
            if ({tb_d_plus, tb_d_minus} !== EXP_K) begin
                miscompares++;
                $display("[TB] FAIL gap_hold[%0d]: got %b expected %b", i, {tb_d_plus, tb_d_minus}, EXP_K);
            end
        end
    endtask

    // Three cycles of eop, then J; a following 0 bit from IDLE must give K.
    task automatic test_eop();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1);
            vectors++;
            if ({tb_d_plus, tb_d_minus} !== EXP_SE0) begin
                miscompares++;
                $display("[TB] FAIL eop_se0[%0d]: got %b expected %b", i, {tb_d_plus, tb_d_minus}, EXP_SE0);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_J) begin
            miscompares++;
            $display("[TB] FAIL eop_to_j: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_J);
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_J) begin
            miscompares++;
            $display("[TB] FAIL idle_j: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_J);
        end
        // data=1 from IDLE stays J (reference J); data=0 next then toggles to K.
        drive_cycle(1'b1, 1'b1, 1'b0);
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_J) begin
            miscompares++;
            $display("[TB] FAIL idle_first_one: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_J);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_K) begin
            miscompares++;
            $display("[TB] FAIL active_toggle: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_K);
        end
    endtask

    // Line at K in ACTIVE: eop with a valid 0 bit must give SE0, not J.
    task automatic test_eop_priority();
        drive_cycle(1'b0, 1'b1, 1'b1);
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_SE0) begin
            miscompares++;
            $display("[TB] FAIL eop_priority: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_SE0);
        end
        // ready with eop low in SE0 is ignored; line returns to J.
        drive_cycle(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_J) begin
            miscompares++;
            $display("[TB] FAIL eop_priority_exit: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_J);
        end
    endtask

    // Single-cycle eop pulses, the second immediately after the J cycle.
    task automatic test_back_to_back_eop();
        logic       eop_seq [5];
        logic [1:0] exp_seq [5];
        eop_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_seq = '{EXP_SE0, EXP_J, EXP_SE0, EXP_J, EXP_J};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, eop_seq[i]);
            vectors++;
            if ({tb_d_plus, tb_d_minus} !== exp_seq[i]) begin
                miscompares++;
                $display("[TB] FAIL b2b_eop[%0d]: got %b expected %b", i, {tb_d_plus, tb_d_minus}, exp_seq[i]);
            end
        end
    endtask

    // Reset pulse while ACTIVE at K, then byte 0x00 from the reset IDLE.
    task automatic test_reset_mid_packet();
        logic [1:0] exp_seq [8];
        exp_seq = '{EXP_K, EXP_J, EXP_K, EXP_J, EXP_K, EXP_J, EXP_K, EXP_J};
        drive_cycle(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_K) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_k: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_K);
        end
        tb_ready = 1'b0;
        tb_n_rst = 1'b0;
        #1;
        vectors++;
        if ({tb_d_plus, tb_d_minus} !== EXP_J) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got %b expected %b", {tb_d_plus, tb_d_minus}, EXP_J);
        end
        #1;
        tb_n_rst = 1'b1;
        @(posedge tb_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            vectors++;
            if ({tb_d_plus, tb_d_minus} !== exp_seq[i]) begin
                miscompares++;
                $display("[TB] FAIL zero_bit[%0d]: got %b expected %b", i, {tb_d_plus, tb_d_minus}, exp_seq[i]);
            end
        end
    endtask

    // SE1 must never appear on the pair.
    always @(negedge tb_clk) begin
        if (tb_n_rst === 1'b1 && tb_d_plus === 1'b1 && tb_d_minus === 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL se1_seen: got %b expected not 11", {tb_d_plus, tb_d_minus});
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        tb_n_rst    = 1'b1;
        tb_data     = 1'b0;
        tb_ready    = 1'b0;
        tb_eop      = 1'b0;
        #1;
        test_reset();
        test_sync_byte();
        test_all_ones_and_gap();
        test_eop();
        test_eop_priority();
        test_back_to_back_eop();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/transmit.md
TRANSMIT -- requirements
Module: transmit

Interface
REQ-001 Parameters: none; line levels fixed to full-speed signalling (J = d_plus 1 / d_minus 0, K = d_plus 0 / d_minus 1, SE0 = both 0).
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  bit-rate clock; all state updates on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 data  input  1  serial bit from upstream shifter (LSB-first byte stream); sampled only when ready=1.
REQ-006 ready  input  1  qualifies data as a valid bit this cycle.
REQ-007 eop  input  1  end-of-packet request; drive SE0 while high.
REQ-008 d_plus  output  1  registered USB D+ line.
REQ-009 d_minus  output  1  registered USB D- line.

Function
REQ-010 Both outputs SHALL be registered; every response appears one clk after the sampling edge.
REQ-011 FSM states SHALL be IDLE, ACTIVE, SE0.
REQ-012 IDLE: drive J; on ready=1 & eop=0 go ACTIVE and encode that bit; on eop=1 go SE0.
REQ-013 ACTIVE, ready=1 & eop=0: NRZI encode; data=0 toggles line J<->K, data=1 holds current level.
REQ-014 ACTIVE, ready=0 & eop=0: hold current line level unchanged (inter-byte gap), stay ACTIVE.
REQ-015 SE0: drive d_plus=0, d_minus=0 every cycle eop=1; on eop=0 go IDLE, drive J next cycle.
REQ-016 eop SHALL have priority over ready in every state; a bit presented with eop=1 is discarded.
REQ-017 NRZI reference level SHALL be J on entering ACTIVE from IDLE; first encoded bit is relative to J.
REQ-018 d_plus and d_minus SHALL never both be 1 (SE1 forbidden); outside SE0 they SHALL be complementary.
REQ-019 No bit stuffing is performed; upstream guarantees stream content; block never stalls or back-pressures.
REQ-020 eop asserted for a single cycle SHALL still produce exactly one SE0 cycle followed by J.
REQ-021 eop reasserted while in IDLE after SE0 SHALL re-enter SE0 with no minimum J gap.

Reset
REQ-022 While n_rst=0: state=IDLE, d_plus=1, d_minus=0 (J), NRZI reference=J, asynchronously.
REQ-023 Reset mid-packet (ACTIVE or SE0) SHALL abort immediately to J; first edge after release behaves as IDLE.

Structure
REQ-024 Shared package usb_tx_pkg SHALL hold the state enum (IDLE, ACTIVE, SE0) and line-level constants J, K, SE0 as 2-bit {d_plus,d_minus}.
REQ-025 Single module, no sub-modules; one state register plus one 2-bit line register; next-state/next-line logic combinational.

Verification
REQ-026 Reset: n_rst=0 -> d_plus=1, d_minus=0 immediately; held after release with ready=0, eop=0.
REQ-027 Sync byte 0x80 LSB-first (0,0,0,0,0,0,0,1), ready=1 for 8 cycles from IDLE -> line sequence K,J,K,J,K,J,K,K.
REQ-028 Byte 0xFF (all ones) after line at K -> line stays K for 8 cycles; then ready=0 for 2 cycles -> K held.
REQ-029 eop=1 for 3 cycles after a byte -> 3 cycles SE0 (0/0), then J (1/0), FSM in IDLE.
REQ-030 eop=1 and ready=1 same cycle in ACTIVE -> SE0 next cycle, bit discarded.
REQ-031 n_rst pulsed low during ACTIVE at K -> J immediately; next byte 0x00 -> K,J,K,J,K,J,K,J.
